// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction source for control_unit. A small program memory is filled from
// the switches one word at a time (load mode), then stepped through by a
// program counter in run mode. Each instruction is offered to the consumer
// over a valid/ready handshake; a jump can redirect the PC on the handshake
// cycle, and the unit halts once the next address falls past the program.
//
// Ports:
//   clock_pulse  in   single clock, all state changes on posedge
//   resetn       in   asynchronous active-low reset
//   load_mode    in   level, request program-load mode
//   load_we      in   one-cycle strobe, write load_data at load_ptr
//   load_data    in   [INSTR_W]   instruction word to store
//   run          in   one-cycle strobe, start/restart execution at PC 0
//   instr_ready  in   consumer accepts instr_out this cycle
//   jump_en      in   redirect PC, sampled only on the handshake cycle
//   jump_addr    in   [ADDR_W]    redirect target
//   instr_out    out  [INSTR_W]   current instruction
//   instr_valid  out  instr_out is valid
//   pc           out  [ADDR_W]    address being fetched or presented
//   prog_len     out  [ADDR_W+1]  number of words loaded (0..DEPTH)
//   load_ptr     out  [ADDR_W+1]  next load write address
//   halted       out  high in HALT
//   load_err     out  sticky, a write was attempted while memory was full
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 8
) (
    input  logic               clock_pulse,
    input  logic               resetn,
    input  logic               load_mode,
    input  logic               load_we,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               run,
    input  logic               instr_ready,
    input  logic               jump_en,
    input  logic [ADDR_W-1:0]  jump_addr,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic [ADDR_W:0]    prog_len,
    output logic [ADDR_W:0]    load_ptr,
    output logic               halted,
    output logic               load_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_FETCH,
        S_PRESENT,
        S_HALT
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_W   = (ADDR_W + 1)'(1);

    state_t             state;
    logic [INSTR_W-1:0] mem [DEPTH];

    logic               mem_full;
    logic               mem_we;
    logic               handshake;
    logic [ADDR_W:0]    next_pc;
    logic               past_end;

    // The pointers are one bit wider than the address so that "full" is
    // representable and the next-PC computation cannot wrap back to 0.
    assign mem_full  = (load_ptr >= DEPTH_W);
    assign mem_we    = (state == S_LOAD) && load_we && !mem_full;
    assign handshake = (state == S_PRESENT) && instr_valid && instr_ready;
    assign next_pc   = jump_en ? {1'b0, jump_addr} : ({1'b0, pc} + ONE_W);
    assign past_end  = (next_pc >= prog_len);

    // Program memory write port.
    // NOTE: the storage array deliberately has no reset; clearing it would
    // turn a plain RAM into a bank of resettable flops. Stale words are
    // unreachable because prog_len bounds every fetch.
    always_ff @(posedge clock_pulse) begin
        if (mem_we) begin
            mem[load_ptr[ADDR_W-1:0]] <= load_data;
        end
    end

    // Control FSM with registered outputs. The memory read is folded into
    // the FETCH -> PRESENT transition, giving a one-cycle read latency.
    // NOTE: all state here is updated with non-blocking assignments so that
    // every branch sees the pre-edge values of pc, prog_len and load_ptr.
    always_ff @(posedge clock_pulse or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            pc          <= '0;
            prog_len    <= '0;
            load_ptr    <= '0;
            instr_out   <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            case (state)
                // IDLE and HALT share exit rules; load_mode beats run.
                S_IDLE, S_HALT: begin
                    instr_valid <= 1'b0;
                    if (load_mode) begin
                        state    <= S_LOAD;
                        load_ptr <= '0;
                        prog_len <= '0;
                        load_err <= 1'b0;
                        halted   <= 1'b0;
                    end else if (run && (prog_len != '0)) begin
                        state  <= S_FETCH;
                        pc     <= '0;
                        halted <= 1'b0;
                    end else if (run) begin
                        // Nothing to execute: go straight to HALT.
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end
                end

                // A write strobe is honoured even on the cycle load_mode
                // drops, so the final word is never lost.
                S_LOAD: begin
                    if (load_we) begin
                        if (!mem_full) begin
                            load_ptr <= load_ptr + ONE_W;
                            prog_len <= prog_len + ONE_W;
                        end else begin
                            load_err <= 1'b1;
                        end
                    end
                    if (!load_mode) begin
                        state <= S_IDLE;
                    end
                end

                S_FETCH: begin
                    instr_out   <= mem[pc];
                    instr_valid <= 1'b1;
                    state       <= S_PRESENT;
                end

                // instr_out and pc hold until the consumer accepts.
                S_PRESENT: begin
                    if (handshake) begin
                        instr_valid <= 1'b0;
                        if (past_end) begin
                            // pc keeps the last presented address.
                            state  <= S_HALT;
                            halted <= 1'b1;
                        end else begin
                            pc    <= next_pc[ADDR_W-1:0];
                            state <= S_FETCH;
                        end
                    end
                end

                default: begin
                    state       <= S_IDLE;
                    instr_valid <= 1'b0;
                    halted      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Self-checking bench for instr_fetch_unit. Expected presentations (pc,
// instruction, and the jump to drive on that handshake) are pushed to a
// scoreboard queue before a run and popped as the DUT offers instructions.
// Inputs change and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam int DEPTH   = 16;
    localparam int ADDR_W  = 4;
    localparam int INSTR_W = 8;

    logic               clock_pulse;
    logic               resetn;
    logic               load_mode;
    logic               load_we;
    logic [INSTR_W-1:0] load_data;
    logic               run;
    logic               instr_ready;
    logic               jump_en;
    logic [ADDR_W-1:0]  jump_addr;
    logic [INSTR_W-1:0] instr_out;
    logic               instr_valid;
    logic [ADDR_W-1:0]  pc;
    logic [ADDR_W:0]    prog_len;
    logic [ADDR_W:0]    load_ptr;
    logic               halted;
    logic               load_err;

    instr_fetch_unit #(
        .DEPTH   (DEPTH),
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) dut (
        .clock_pulse (clock_pulse),
        .resetn      (resetn),
        .load_mode   (load_mode),
        .load_we     (load_we),
        .load_data   (load_data),
        .run         (run),
        .instr_ready (instr_ready),
        .jump_en     (jump_en),
        .jump_addr   (jump_addr),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .pc          (pc),
        .prog_len    (prog_len),
        .load_ptr    (load_ptr),
        .halted      (halted),
        .load_err    (load_err)
    );

    initial clock_pulse = 1'b0;
    always #5 clock_pulse = ~clock_pulse;

    typedef struct {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
        logic               jmp;
        logic [ADDR_W-1:0]  jaddr;
    } exp_t;

    exp_t               sb[$];
    logic [INSTR_W-1:0] prog [0:16];
    int                 checks = 0;
    int                 errors = 0;

    task automatic tick();
        @(posedge clock_pulse);
        @(negedge clock_pulse);
    endtask

    task automatic push_exp(input logic [ADDR_W-1:0] p, input logic [INSTR_W-1:0] ins,
                            input logic j, input logic [ADDR_W-1:0] ja);
        exp_t e;
        e.pc = p; e.instr = ins; e.jmp = j; e.jaddr = ja;
        sb.push_back(e);
    endtask

    task automatic set_small_prog();
        prog[0] = 8'h13; prog[1] = 8'h15; prog[2] = 8'h31;
    endtask

    // Enter LOAD, strobe n words; load_mode drops together with the last strobe.
    task automatic load_prog(input int n);
        load_mode = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            load_we   = 1'b1;
            load_data = prog[i];
            if (i == n - 1) load_mode = 1'b0;
            tick();
        end
        load_we   = 1'b0;
        load_mode = 1'b0;
        if (n == 0) tick();
    endtask

    task automatic pulse_run();
        run = 1'b1;
        tick();
        run = 1'b0;
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 8 && !ok; i++) begin
            if (instr_valid === 1'b1) ok = 1'b1;
            else tick();
        end
    endtask

    // Consume presentations with ready held high, popping the scoreboard.
    // While nothing is valid a decoy jump is driven; it must be ignored.
    task automatic drain_scoreboard(input int max_cycles, output bit done);
        exp_t e;
        done        = 1'b0;
        instr_ready = 1'b1;
        for (int c = 0; c < max_cycles && !done; c++) begin
            if (instr_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got instr 0x%02h at pc %0d, required no presentation",
                             instr_out, pc);
                    jump_en = 1'b0;
                end else begin
                    e = sb.pop_front();
                    if (instr_out !== e.instr || pc !== e.pc) begin
                        errors++;
                        $display("FAIL sb_present: got instr 0x%02h pc %0d, required instr 0x%02h pc %0d",
                                 instr_out, pc, e.instr, e.pc);
                    end
                    jump_en   = e.jmp;
                    jump_addr = e.jaddr;
                end
            end else begin
                if (sb.size() == 0 && halted === 1'b1) done = 1'b1;
                jump_en   = 1'b1;
                jump_addr = '0;
            end
            if (!done) tick();
        end
        jump_en   = 1'b0;
        jump_addr = '0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        checks++;
        if (instr_valid !== 1'b0 || halted !== 1'b0 || load_err !== 1'b0 || instr_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_flags: got valid %b halted %b err %b instr 0x%02h, required 0 0 0 0x00",
                     instr_valid, halted, load_err, instr_out);
        end
        checks++;
        if (pc !== 4'd0 || prog_len !== 5'd0 || load_ptr !== 5'd0) begin
            errors++;
            $display("FAIL reset_ptrs: got pc %0d len %0d ptr %0d, required 0 0 0", pc, prog_len, load_ptr);
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_load();
        set_small_prog();
        load_prog(3);
        checks++;
        if (prog_len !== 5'd3 || load_ptr !== 5'd3) begin
            errors++;
            $display("FAIL load_count: got len %0d ptr %0d, required 3 3", prog_len, load_ptr);
        end
        checks++;
        if (halted !== 1'b0 || instr_valid !== 1'b0 || load_err !== 1'b0) begin
            errors++;
            $display("FAIL load_idle: got halted %b valid %b err %b, required 0 0 0",
                     halted, instr_valid, load_err);
        end
    endtask

    // Full-throughput stream: valid alternates 1,0 and each word shows once.
    task automatic test_run_stream();
        exp_t e;
        logic exp_v;
        push_exp(4'd0, 8'h13, 1'b0, '0);
        push_exp(4'd1, 8'h15, 1'b0, '0);
        push_exp(4'd2, 8'h31, 1'b0, '0);
        instr_ready = 1'b1;
        pulse_run();
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL stream_fetch: got valid %b, required 0", instr_valid);
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            exp_v = (c % 2 == 0);
            checks++;
            if (instr_valid !== exp_v) begin
                errors++;
                $display("FAIL stream_valid[%0d]: got %b, required %b", c, instr_valid, exp_v);
            end
            if (exp_v && sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if (instr_out !== e.instr || pc !== e.pc) begin
                    errors++;
                    $display("FAIL stream_word[%0d]: got 0x%02h pc %0d, required 0x%02h pc %0d",
                             c, instr_out, pc, e.instr, e.pc);
                end
            end
        end
        checks++;
        if (halted !== 1'b1 || pc !== 4'd2 || sb.size() != 0) begin
            errors++;
            $display("FAIL stream_halt: got halted %b pc %0d left %0d, required 1 2 0",
                     halted, pc, sb.size());
        end
    endtask

    task automatic test_backpressure();
        bit done;
        push_exp(4'd0, 8'h13, 1'b0, '0);
        push_exp(4'd1, 8'h15, 1'b0, '0);
        push_exp(4'd2, 8'h31, 1'b0, '0);
        instr_ready = 1'b0;
        pulse_run();
        tick();
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (instr_valid !== 1'b1 || instr_out !== sb[0].instr || pc !== sb[0].pc) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got valid %b 0x%02h pc %0d, required 1 0x%02h pc %0d",
                         c, instr_valid, instr_out, pc, sb[0].instr, sb[0].pc);
            end
            if (c < 5) tick();
        end
        instr_ready = 1'b1;
        tick();
        void'(sb.pop_front());
        checks++;
        if (instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got valid %b, required 0", instr_valid);
        end
        tick();
        drain_scoreboard(20, done);
        checks++;
        if (!done || pc !== 4'd2) begin
            errors++;
            $display("FAIL bp_drain: got done %b pc %0d, required 1 2", done, pc);
        end
    endtask

    task automatic test_jump();
        bit done;
        push_exp(4'd0, 8'h13, 1'b0, '0);
        push_exp(4'd1, 8'h15, 1'b0, '0);
        push_exp(4'd2, 8'h31, 1'b1, 4'd0);
        push_exp(4'd0, 8'h13, 1'b0, '0);
        push_exp(4'd1, 8'h15, 1'b1, 4'd5);
        instr_ready = 1'b1;
        pulse_run();
        drain_scoreboard(40, done);
        checks++;
        if (!done || halted !== 1'b1 || pc !== 4'd1) begin
            errors++;
            $display("FAIL jump_halt: got done %b halted %b pc %0d, required 1 1 1", done, halted, pc);
        end
    endtask

    task automatic test_overflow();
        bit done;
        for (int i = 0; i < 17; i++) prog[i] = 8'hA0 + 8'(i);
        load_prog(17);
        checks++;
        if (prog_len !== 5'd16 || load_ptr !== 5'd16 || load_err !== 1'b1) begin
            errors++;
            $display("FAIL ovf_load: got len %0d ptr %0d err %b, required 16 16 1",
                     prog_len, load_ptr, load_err);
        end
        for (int i = 0; i < 16; i++) push_exp(4'(i), prog[i], 1'b0, '0);
        instr_ready = 1'b1;
        pulse_run();
        drain_scoreboard(80, done);
        checks++;
        if (!done || pc !== 4'd15) begin
            errors++;
            $display("FAIL ovf_halt: got done %b pc %0d, required 1 15", done, pc);
        end
    endtask

    task automatic test_empty_run();
        load_prog(0);
        checks++;
        if (prog_len !== 5'd0 || load_err !== 1'b0) begin
            errors++;
            $display("FAIL empty_load: got len %0d err %b, required 0 0", prog_len, load_err);
        end
        pulse_run();
        checks++;
        if (halted !== 1'b1 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL empty_run: got halted %b valid %b, required 1 0", halted, instr_valid);
        end
        tick();
        tick();
        checks++;
        if (halted !== 1'b1 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL empty_stay: got halted %b valid %b, required 1 0", halted, instr_valid);
        end
    endtask

    task automatic test_load_priority();
        set_small_prog();
        load_prog(3);
        load_mode = 1'b1;
        run       = 1'b1;
        tick();
        checks++;
        if (prog_len !== 5'd0 || load_ptr !== 5'd0 || halted !== 1'b0 || instr_valid !== 1'b0) begin
            errors++;
            $display("FAIL prio_load: got len %0d ptr %0d halted %b valid %b, required 0 0 0 0",
                     prog_len, load_ptr, halted, instr_valid);
        end
        tick();
        checks++;
        if (instr_valid !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL prio_run_ignored: got valid %b halted %b, required 0 0", instr_valid, halted);
        end
        run       = 1'b0;
        load_mode = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_present();
        bit ok;
        set_small_prog();
        load_prog(3);
        instr_ready = 1'b0;
        pulse_run();
        wait_valid(ok);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        wait_valid(ok);
        checks++;
        if (!ok || pc !== 4'd1) begin
            errors++;
            $display("FAIL rst_setup: got valid_seen %b pc %0d, required 1 1", ok, pc);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if (instr_valid !== 1'b0 || pc !== 4'd0 || prog_len !== 5'd0 || load_ptr !== 5'd0) begin
            errors++;
            $display("FAIL rst_async: got valid %b pc %0d len %0d ptr %0d, required 0 0 0 0",
                     instr_valid, pc, prog_len, load_ptr);
        end
        tick();
        resetn = 1'b1;
        pulse_run();
        tick();
        checks++;
        if (instr_valid !== 1'b0 || halted !== 1'b1) begin
            errors++;
            $display("FAIL rst_prog_lost: got valid %b halted %b, required 0 1", instr_valid, halted);
        end
    endtask

    initial begin
        resetn      = 1'b0;
        load_mode   = 1'b0;
        load_we     = 1'b0;
        load_data   = '0;
        run         = 1'b0;
        instr_ready = 1'b0;
        jump_en     = 1'b0;
        jump_addr   = '0;
        @(negedge clock_pulse);
        test_reset();
        test_load();
        test_run_stream();
        test_backpressure();
        test_jump();
        test_overflow();
        test_empty_run();
        test_load_priority();
        test_reset_mid_present();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream instruction source for control_unit. Replaces direct SW sampling in the Fetch stage.
- Holds a small program memory that is loaded from the switches one 8-bit instruction at a time.
- In run mode it steps a program counter and presents each instruction over a valid/ready handshake.
- Supports a jump redirect and halts cleanly at the end of the program.

Parameters:
- DEPTH, 16, number of instruction words in program memory.
- ADDR_W, 4, PC/pointer width (log2 DEPTH).
- INSTR_W, 8, instruction width (matches IR).

Ports:
- clock_pulse  input  1  single clock; all state changes on posedge.
- resetn  input  1  asynchronous, active-low reset.
- load_mode  input  1  level; request program-load mode.
- load_we  input  1  one-cycle strobe; write load_data at load_ptr.
- load_data  input  INSTR_W  instruction word to store.
- run  input  1  one-cycle strobe; start or restart execution at PC 0.
- instr_ready  input  1  consumer (control_unit) accepts instr_out this cycle.
- jump_en  input  1  redirect PC; sampled only on the handshake cycle.
- jump_addr  input  ADDR_W  redirect target.
- instr_out  output  INSTR_W  current instruction.
- instr_valid  output  1  instr_out is valid.
- pc  output  ADDR_W  address of the instruction being fetched or presented.
- prog_len  output  ADDR_W+1  number of words loaded (0..DEPTH).
- load_ptr  output  ADDR_W+1  next load write address.
- halted  output  1  high in HALT state.
- load_err  output  1  sticky flag; a write was attempted while memory was full.

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; pc=0; prog_len=0; load_ptr=0.
  - instr_out=0; instr_valid=0; halted=0; load_err=0.
  - Memory contents are not reset. With prog_len=0 they are unreachable.
- Program memory: DEPTH x INSTR_W, synchronous write, synchronous read with 1-cycle latency.
- States: IDLE, LOAD, FETCH, PRESENT, HALT.
- IDLE and HALT:
  - load_mode=1 -> LOAD. Clear load_ptr, prog_len and load_err.
  - Otherwise, run=1 with prog_len!=0 -> FETCH with pc=0.
  - Otherwise, run=1 with prog_len==0 -> HALT.
  - load_mode takes priority over run.
- LOAD:
  - load_we=1 with load_ptr<DEPTH: write mem[load_ptr]=load_data, then increment load_ptr and prog_len.
  - load_we=1 with load_ptr==DEPTH: write dropped, load_err<=1.
  - load_mode=0 -> IDLE. A load_we in the same cycle is still honoured.
  - run is ignored in LOAD.
- FETCH:
  - Memory read of mem[pc] is issued; instr_valid=0.
  - Next cycle -> PRESENT; instr_out<=mem[pc]; instr_valid<=1.
- PRESENT:
  - instr_out and pc are held stable while instr_valid=1 and instr_ready=0.
  - On handshake (instr_valid & instr_ready):
    - next = jump_en ? jump_addr : pc+1. Compute in ADDR_W+1 bits; no wrap.
    - next>=prog_len -> HALT with instr_valid<=0. pc keeps the last presented address.
    - Otherwise pc<=next, instr_valid<=0, -> FETCH.
  - Peak throughput is one instruction per 2 cycles.
  - jump_en is ignored outside the handshake cycle.
  - load_mode and run are ignored in FETCH and PRESENT.
- HALT: halted=1, instr_valid=0. Exit rules are as for IDLE.
- halted=0 in all other states.
- Reset mid-run or mid-load: everything returns to reset values immediately. Loaded program is lost (prog_len=0).
- instr_ready while instr_valid=0 has no effect.

Test Plan:
- Reset, then load 0x13, 0x15, 0x31 (3 load_we strobes), drop load_mode -> prog_len=3, load_ptr=3, state IDLE, halted=0.
- Continue from the previous case: pulse run, hold instr_ready=1 -> instr_out sequence 0x13, 0x15, 0x31, each valid for exactly 1 cycle with 1-cycle gaps. Then halted=1, pc=2.
- Backpressure: hold instr_ready=0 for 5 cycles after valid rises on 0x13 -> instr_out=0x13, instr_valid=1 and pc=0 all stable for the 5 cycles. Raise ready -> next instruction 0x15.
- Jump: with the 3-word program, assert jump_en=1, jump_addr=0 on the handshake of pc=2 -> 0x13 is presented again. jump_addr=5 on any handshake -> HALT.
- Overflow: load 17 words -> prog_len=16, load_err=1, mem[15] holds the 16th word. Run 16 handshakes -> HALT with pc=15 (no wrap to 0).
- Edge and reset cases:
  - run with prog_len=0 -> HALT immediately.
  - resetn low during PRESENT -> instr_valid=0, pc=0, prog_len=0 asynchronously.
  - load_mode and run asserted together in IDLE -> LOAD wins.
